// File: rtl/stack_ctrl.sv
// stack_ctrl: turns two raw push-buttons and four data switches into
// single-cycle push/pop strobes for a downstream 8x4 stack, captures popped
// data for display and tracks rejected requests.
//
// Ports
//   clk            system clock, rising edge
//   rstN           synchronous active-low reset
//   btn_push       raw push button (asynchronous, active-high)
//   btn_pop        raw pop button (asynchronous, active-high)
//   sw_data[3:0]   raw data switches (asynchronous)
//   stack_full     downstream stack full flag
//   stack_empty    downstream stack empty flag
//   stack_data_out downstream read data, valid the cycle after pop is sampled
//   push, pop      single-cycle strobes to the stack (only ever in ISSUE)
//   data_in[3:0]   write data, latched when a request is accepted in IDLE
//   disp_data[3:0] last popped value
//   disp_valid     disp_data holds a popped value
//   err            sticky: the most recent request was rejected
//   err_count[7:0] saturating count of rejected requests
//   fsm_state[1:0] debug view of the FSM state (0 IDLE, 1 ISSUE, 2 CAPTURE)
//
// Handshake: there is no ready back-pressure. push/pop are one-cycle
// strobes the stack must act on in the cycle they are high; the stack's
// read data is taken one cycle after a pop strobe.
module stack_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       btn_push,
  input  logic       btn_pop,
  input  logic [3:0] sw_data,
  input  logic       stack_full,
  input  logic       stack_empty,
  input  logic [3:0] stack_data_out,
  output logic       push,
  output logic       pop,
  output logic [3:0] data_in,
  output logic [3:0] disp_data,
  output logic       disp_valid,
  output logic       err,
  output logic [7:0] err_count,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Counter reaching DEBOUNCE_CYCLES is the toggle point, so compare with D-1.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Synchronizer layout: [5]=pop, [4]=push, [3:0]=switches.
  logic [5:0]  sync1;
  logic [5:0]  sync2;
  logic [15:0] cnt [2];  // index 0 = push button, 1 = pop button
  logic [1:0]  deb;
  logic [1:0]  deb_prev;
  logic        req_push;
  logic        req_pop;
  logic        pend_push;
  logic        pend_pop;
  logic        reject;
  logic        accept;
  state_t      state;
  state_t      state_next;

  assign fsm_state = state;
  assign req_push  = deb[0] & ~deb_prev[0];
  assign req_pop   = deb[1] & ~deb_prev[1];

  // Synchronizers, debouncers and edge history.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1    <= {btn_pop, btn_push, sw_data};
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[4+i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync2[4+i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    reject     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // Requests arriving in any other state are simply not looked at.
        if (req_push || req_pop) state_next = ISSUE;
      end
      ISSUE: begin
        if (pend_push && pend_pop) begin
          // Simultaneous push+pop is always issued, even on an empty stack.
          push   = 1'b1;
          pop    = 1'b1;
          accept = 1'b1;
        end else if (pend_push) begin
          push   = ~stack_full;
          accept = ~stack_full;
          reject = stack_full;
        end else if (pend_pop) begin
          pop    = ~stack_empty;
          accept = ~stack_empty;
          reject = stack_empty;
        end
        state_next = (pop && !stack_empty) ? CAPTURE : IDLE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      pend_push  <= 1'b0;
      pend_pop   <= 1'b0;
      data_in    <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (req_push || req_pop)) begin
        data_in   <= sync2[3:0];
        pend_push <= req_push;
        pend_pop  <= req_pop;
      end
      if (reject) begin
        err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (accept) begin
        err <= 1'b0;
      end
      if (state == CAPTURE) begin
        disp_data  <= stack_data_out;
        disp_valid <= 1'b1;
      end
    end
  end

endmodule
